// File: rtl/pulse_train_generator_pkg.sv
// ============================================================================
// pulse_train_generator_pkg : shared state encoding and default widths
// Revision: 1.0
// ============================================================================
`default_nettype none

package pulse_train_generator_pkg;

  localparam int C_DEF_WIDTH = 8;
  localparam int C_DEF_CNT_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_HIGH = HIGH,
    ST_LOW  = LOW
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_train_generator_if.sv
// ============================================================================
// pulse_train_generator_if : control/status bundle of the pulse train generator
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pulse_train_generator_if
  import pulse_train_generator_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int CNT_W = C_DEF_CNT_W
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] width;
  logic [WIDTH-1:0] gap;
  logic [CNT_W-1:0] count;
  logic             pulse_out;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, width, gap, count,
    input  pulse_out, busy, done
  );

  modport slave (
    input  start, abort, width, gap, count,
    output pulse_out, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/pulse_train_generator_phase_counter.sv
// ============================================================================
// pulse_phase_counter : loadable down-counter with enable and zero flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_phase_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             enable,
  input  wire logic [WIDTH-1:0] load_value,
  output      logic             zero
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_value;

  // Holds at zero rather than wrapping; load takes priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_value;
    end else if (enable && (r_value != '0)) begin
      r_value <= r_value - C_ONE;
    end
  end

  assign zero = (r_value == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_train_generator.sv
// ============================================================================
// pulse_train_generator : emits count pulses of width cycles separated by gap
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_train_generator
  import pulse_train_generator_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int CNT_W = C_DEF_CNT_W
) (
  input wire logic                 clk,
  input wire logic                 rst,
  pulse_train_generator_if.slave   bus
);

  localparam logic [WIDTH-1:0] C_W_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] C_C_ONE = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_width;
  logic [WIDTH-1:0] r_gap;
  logic [CNT_W-1:0] r_left;
  logic             r_pulse_out;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_phase_zero;
  logic             w_load;
  logic             w_enable;
  logic [WIDTH-1:0] w_load_value;
  logic [WIDTH-1:0] w_gap_m1;

  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.abort &&
                    (bus.width != '0) && (bus.count != '0);

  // A zero gap still yields one low cycle so adjacent pulses stay separable.
  assign w_gap_m1 = (r_gap == '0) ? '0 : (r_gap - C_W_ONE);

  always_comb begin
    w_load       = 1'b0;
    w_enable     = 1'b0;
    w_load_value = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_load_value = bus.width - C_W_ONE;
        end
      end
      ST_HIGH: begin
        if (bus.abort) begin
          w_load = 1'b1;
        end else if (w_phase_zero) begin
          if (r_left != '0) begin
            w_load       = 1'b1;
            w_load_value = w_gap_m1;
          end
        end else begin
          w_enable = 1'b1;
        end
      end
      ST_LOW: begin
        if (bus.abort) begin
          w_load = 1'b1;
        end else if (w_phase_zero) begin
          w_load       = 1'b1;
          w_load_value = r_width - C_W_ONE;
        end else begin
          w_enable = 1'b1;
        end
      end
      default: begin
        w_load = 1'b1;
      end
    endcase
  end

  pulse_phase_counter #(
    .WIDTH (WIDTH)
  ) u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .enable     (w_enable),
    .load_value (w_load_value),
    .zero       (w_phase_zero)
  );

  // r_left counts pulses still to come after the one currently being emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_width     <= '0;
      r_gap       <= '0;
      r_left      <= '0;
      r_pulse_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_width     <= bus.width;
            r_gap       <= bus.gap;
            r_left      <= bus.count - C_C_ONE;
            r_state     <= ST_HIGH;
            r_pulse_out <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (bus.abort) begin
            r_state     <= ST_IDLE;
            r_left      <= '0;
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_phase_zero) begin
            r_pulse_out <= 1'b0;
            if (r_left != '0) begin
              r_state <= ST_LOW;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_LOW: begin
          if (bus.abort) begin
            r_state     <= ST_IDLE;
            r_left      <= '0;
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_phase_zero) begin
            r_state     <= ST_HIGH;
            r_left      <= r_left - C_C_ONE;
            r_pulse_out <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_left      <= '0;
          r_pulse_out <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out = r_pulse_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_generator.sv
// ============================================================================
// tb_pulse_train_generator : scoreboard bench with a waveform-level reference
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_train_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pulse_train_generator_if #(.WIDTH(8), .CNT_W(8)) bus ();

  pulse_train_generator #(
    .WIDTH (8),
    .CNT_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Each entry is the expected {pulse_out, busy, done} of one future cycle.
  typedef logic [2:0] obs_t;
  obs_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: pulse/busy/done got %b expected %b",
                  name, $time, act, exp);
  endtask

  // Whole train as a waveform: pulses of w highs, max(g,1) lows between, then done.
  task automatic push_train(input int w, input int g, input int c);
    for (int p = 0; p < c; p++) begin
      for (int i = 0; i < w; i++) exp_q.push_back(3'b110);
      if (p != c - 1) begin
        for (int i = 0; i < ((g == 0) ? 1 : g); i++) exp_q.push_back(3'b010);
      end
    end
    exp_q.push_back(3'b001);
  endtask

  // Inputs applied for the next rising edge; the model is idle when nothing is queued.
  task automatic cyc(input logic s, input logic a,
                     input logic [7:0] w, input logic [7:0] g, input logic [7:0] c);
    @(negedge clk);
    #1;
    bus.start = s;
    bus.abort = a;
    bus.width = w;
    bus.gap   = g;
    bus.count = c;
    if (a) begin
      exp_q.delete();
    end else if (s && (w != 0) && (c != 0) && (exp_q.size() == 0)) begin
      push_train(int'(w), int'(g), int'(c));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin : monitor
    obs_t exp;
    forever begin
      @(negedge clk);
      exp = 3'b000;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      check("cycle", {bus.pulse_out, bus.busy, bus.done}, exp);
    end
  end

  initial begin : stimulus
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.width = '0;
    bus.gap   = '0;
    bus.count = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    cyc(1'b1, 1'b0, 8'd3, 8'd0, 8'd1);   idle(6);
    cyc(1'b1, 1'b0, 8'd2, 8'd3, 8'd3);   idle(14);
    cyc(1'b1, 1'b0, 8'd1, 8'd0, 8'd4);   idle(10);
    cyc(1'b1, 1'b0, 8'd0, 8'd3, 8'd2);   idle(3);
    cyc(1'b1, 1'b0, 8'd4, 8'd1, 8'd0);   idle(3);

    // Restart requests and parameter churn while busy must not disturb the train.
    cyc(1'b1, 1'b0, 8'd3, 8'd2, 8'd2);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'd7, 8'd7, 8'd7);
    idle(6);

    cyc(1'b1, 1'b0, 8'd10, 8'd0, 8'd2);
    idle(3);
    cyc(1'b1, 1'b1, 8'd10, 8'd0, 8'd2);
    idle(4);

    cyc(1'b1, 1'b0, 8'd2, 8'd5, 8'd2);
    idle(3);
    @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1 check("async_reset", {bus.pulse_out, bus.busy, bus.done}, 3'b000);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b0, 8'd2, 8'd1, 8'd2);   idle(8);

    cyc(1'b1, 1'b0, 8'd255, 8'd0, 8'd1); idle(258);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'd2, 8'd0, 8'd1);
    idle(5);

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
          8'($urandom_range(0, 12)), 8'($urandom_range(0, 5)),
          8'($urandom_range(0, 5)));
    end
    idle(90);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
Generates a programmable train of active-high pulses: N pulses, each H cycles high, separated by G low cycles. It is the transmit-side counterpart of the pulse-width measurement blocks in the signals library. Used to drive strobes and test stimulus, and to produce timed enables for downstream logic. A start/busy/done handshake lets a controller launch one train at a time.

Parameters:
WIDTH, 8, bit width of high-time and gap counters (max 2^WIDTH-1 cycles each)
CNT_W, 8, bit width of pulse-count field (max 2^CNT_W-1 pulses per train)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  launch request, sampled only while idle
abort  input  1  terminate current train
width  input  WIDTH  high time per pulse in cycles, latched at accepted start
gap  input  WIDTH  low time between pulses in cycles, latched at accepted start
count  input  CNT_W  number of pulses in train, latched at accepted start
pulse_out  output  1  generated pulse, registered
busy  output  1  high while a train is in progress
done  output  1  one-cycle strobe at normal train completion

Behaviour:
- Reset: asynchronous, active-high; clk and rst are the only clock/reset. All outputs and state are forced immediately: pulse_out=0, busy=0, done=0, state=IDLE, counters=0. Reset mid-train kills the train with no done.
- States: IDLE, HIGH, LOW.
- IDLE: start=1 with width!=0, count!=0 and abort=0 at edge T is accepted.
  - Latches width, gap and count.
  - At T: state moves to HIGH, pulse_out=1, busy=1.
  - start with width==0 or count==0 is ignored: no busy, no done, stays IDLE.
- HIGH: pulse_out is high for exactly the latched width cycles.
  - Last high cycle with pulses remaining: state moves to LOW and pulse_out=0.
  - Last high cycle of the last pulse: state moves to IDLE, pulse_out=0, busy=0, done=1 for exactly one cycle.
  - No trailing gap after the final pulse.
- LOW: pulse_out is low for max(gap,1) cycles. gap==0 is treated as 1 so pulses stay separable. Then the state moves to HIGH and pulse_out=1.
- Latency: pulse_out rises on the edge that accepts start (visible one cycle after start is presented).
- Train length: busy cycles = count*width + (count-1)*max(gap,1).
- Input stability: start while busy is ignored. Changes to width, gap or count during a train have no effect.
- Back-to-back: start asserted in the done cycle is accepted (state is IDLE), giving exactly one low cycle between trains.
- Abort:
  - In HIGH or LOW, abort=1 at an edge forces IDLE, pulse_out=0 and busy=0 at that edge. No done is issued.
  - Abort has priority over normal completion in the same cycle.
  - In IDLE, abort has priority over start (start is dropped).
- Counters:
  - Phase counter is a WIDTH-bit down-counter loaded with width-1 or max(gap,1)-1; a phase ends when it reaches 0.
  - Pulse counter is a CNT_W-bit down-counter.
  - Neither counter ever wraps.
- pulse_out, busy and done are driven directly from registers (glitch-free).

Decomposition:
- Shared signals package holds:
  - state encoding constants IDLE=2'd0, HIGH=2'd1, LOW=2'd2
  - default width constants.
- One natural sub-module, pulse_phase_counter: a loadable WIDTH-bit down-counter with load, enable and zero flag. It is instantiated for the phase timing.
- Pulse-count and FSM logic stay in the top module.

Test Plan:
- WIDTH=8; width=3, count=1, start at edge 0 -> pulse_out=1 in cycles 1-3; cycle 4: pulse_out=0, busy=0, done=1; cycle 5: done=0.
- width=2, gap=3, count=3 -> pulse_out sequence 1,1,0,0,0,1,1,0,0,0,1,1. busy high for 12 cycles. Exactly one done strobe, after the third pulse.
- width=1, gap=0, count=4 -> alternating 1,0,1,0,1,0,1 (gap forced to 1); done once.
- start with width=0, and separately with count=0 -> no activity. start re-asserted mid-train and width changed mid-train -> train unchanged.
- width=10, count=2, abort in cycle 5 -> pulse_out=0 and busy=0 from the next cycle, no done. Separately, assert rst mid-LOW -> outputs 0 immediately, then a new start works normally.
- width=255, count=1 -> exactly 255 high cycles with no counter wrap. start held through the done cycle -> second train begins after exactly one low cycle.
